// File: rtl/bch_enc_serial_if.sv
// Bit-serial message-in / codeword-out stream for the BCH encoder.
interface bch_enc_serial_if;
  logic isop;
  logic ival;
  logic idat;
  logic ordy;
  logic osop;
  logic oval;
  logic oeop;
  logic odat;

  modport master (
    output isop, ival, idat,
    input  ordy, osop, oval, oeop, odat
  );

  modport slave (
    input  isop, ival, idat,
    output ordy, osop, oval, oeop, odat
  );
endinterface

// File: rtl/bch_enc_serial.sv
// Bit-serial systematic BCH(n,k) encoder: passes k message bits through, then
// appends deg(g) parity bits of x^deg(g)*m(x) mod g(x); g(x) is built at elaboration.
module bch_enc_serial #(
  parameter int unsigned m      = 4,
  parameter int unsigned k_max  = 5,
  parameter int unsigned d      = 7,
  parameter int unsigned n      = 15,
  parameter int unsigned irrpol = 19
) (
  input  logic iclk,
  input  logic ireset_n,
  input  logic iclkena,
  bch_enc_serial_if.slave bus
);

  // GF(2^m) multiply modulo irrpol (shift-and-add).
  function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b);
    int unsigned acc;
    int unsigned x;
    acc = 0;
    x   = a;
    for (int i = 0; i < int'(m); i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x[m]) x = x ^ irrpol;
    end
    return acc;
  endfunction

  // Evaluate a binary polynomial at a field element (Horner).
  function automatic int unsigned poly_eval(input logic [63:0] p, input int unsigned x);
    int unsigned r;
    r = 0;
    for (int j = 63; j >= 0; j--) r = gf_mul(r, x) ^ 32'(p[j]);
    return r;
  endfunction

  function automatic logic [63:0] clmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) r = r ^ (a << i);
    end
    return r;
  endfunction

  // g = LCM of minimal polynomials of alpha^1, alpha^3 .. alpha^(d-2); a minimal
  // polynomial is only multiplied in when its root is not already a root of g.
  function automatic logic [63:0] gen_poly();
    logic [63:0] g;
    logic [63:0] p;
    int unsigned a;
    g = 64'd1;
    a = 1;
    for (int i = 1; i <= int'(d) - 2; i++) begin
      a = gf_mul(a, 2);
      if ((i % 2 == 1) && (poly_eval(g, a) != 0)) begin
        p = '0;
        for (int c = 2; c < int'(2 << m); c++) begin
          if ((p == '0) && (poly_eval(64'(c), a) == 0)) p = 64'(c);
        end
        g = clmul(g, p);
      end
    end
    return g;
  endfunction

  function automatic int unsigned poly_deg(input logic [63:0] p);
    int unsigned r;
    r = 0;
    for (int j = 0; j < 64; j++) begin
      if (p[j]) r = 32'(j);
    end
    return r;
  endfunction

  localparam logic [63:0]   g_full = gen_poly();
  localparam int unsigned   gdeg   = poly_deg(g_full);
  localparam int unsigned   k      = n - gdeg;
  localparam logic [gdeg-1:0] g_low = g_full[gdeg-1:0];
  localparam int unsigned   cnt_w  = $clog2(((gdeg > k) ? gdeg : k) + 1);

  if ((n > (1 << m) - 1) || (gdeg >= n)) begin : g_bad_len
    $error("bch_enc_serial: n=%0d invalid for m=%0d, deg(g)=%0d", n, m, gdeg);
  end
  if (k > k_max) begin : g_bad_k
    $error("bch_enc_serial: k=%0d exceeds k_max=%0d", k, k_max);
  end

  localparam logic [0:0] st_data   = 1'b0;
  localparam logic [0:0] st_parity = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q,   cnt_d;
  logic [gdeg-1:0]  lfsr_q,  lfsr_d;
  logic             osop_q,  osop_d;
  logic             oval_q,  oval_d;
  logic             oeop_q,  oeop_d;
  logic             odat_q,  odat_d;
  logic             fb;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= st_data;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      osop_q  <= 1'b0;
      oval_q  <= 1'b0;
      oeop_q  <= 1'b0;
      odat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      osop_q  <= osop_d;
      oval_q  <= oval_d;
      oeop_q  <= oeop_d;
      odat_q  <= odat_d;
    end
  end

  // Next state: everything holds when iclkena is low, outputs clear on idle cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    osop_d  = osop_q;
    oval_d  = oval_q;
    oeop_d  = oeop_q;
    odat_d  = odat_q;
    fb      = 1'b0;
    if (iclkena) begin
      osop_d = 1'b0;
      oval_d = 1'b0;
      oeop_d = 1'b0;
      odat_d = 1'b0;
      case (state_q)
        st_data: begin
          if (bus.ival) begin
            if (bus.isop) begin
              // A new isop always restarts the frame from a cleared LFSR.
              fb     = bus.idat;
              lfsr_d = fb ? g_low : '0;
              oval_d = 1'b1;
              osop_d = 1'b1;
              odat_d = bus.idat;
              if (k == 1) begin
                state_d = st_parity;
                cnt_d   = cnt_w'(gdeg);
              end else begin
                cnt_d   = cnt_w'(1);
              end
            end else if (cnt_q != '0) begin
              fb     = bus.idat ^ lfsr_q[gdeg-1];
              lfsr_d = (lfsr_q << 1) ^ (fb ? g_low : '0);
              oval_d = 1'b1;
              odat_d = bus.idat;
              if (cnt_q == cnt_w'(k - 1)) begin
                state_d = st_parity;
                cnt_d   = cnt_w'(gdeg);
              end else begin
                cnt_d   = cnt_q + cnt_w'(1);
              end
            end
          end
        end
        default: begin
          oval_d = 1'b1;
          odat_d = lfsr_q[gdeg-1];
          lfsr_d = lfsr_q << 1;
          cnt_d  = cnt_q - cnt_w'(1);
          if (cnt_q == cnt_w'(1)) begin
            oeop_d  = 1'b1;
            state_d = st_data;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  assign bus.ordy = (state_q == st_data);
  assign bus.osop = osop_q;
  assign bus.oval = oval_q;
  assign bus.oeop = oeop_q;
  assign bus.odat = odat_q;

endmodule

// File: tb/tb_bch_enc_serial.sv
// Bench for bch_enc_serial (BCH(15,5), g = 0x537): scoreboard of expected output
// bits, constant codeword table, syndrome check of every completed codeword.
module tb_bch_enc_serial;
  localparam int unsigned N    = 15;
  localparam int unsigned K    = 5;
  localparam int unsigned GDEG = 10;
  localparam logic [10:0] G    = 11'h537;

  typedef struct packed {
    logic sop;
    logic dat;
    logic eop;
  } exp_t;

  typedef struct {
    logic [K-1:0]    msg;
    logic [GDEG-1:0] par;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  bch_enc_serial_if bus();

  bch_enc_serial #(.m(4), .k_max(5), .d(7), .n(15), .irrpol(19)) dut (
    .iclk     (clk),
    .ireset_n (rst_n),
    .iclkena  (ce),
    .bus      (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Encoder reference state
  int           m_cnt = 0;
  int           m_par_left = 0;
  logic [K-1:0] m_msg = '0;

  // Monitor state
  logic         mon_en = 1'b0;
  logic         ce_s;
  exp_t         e;
  int           cyc = 0;
  int           run = 0;
  int           run_at_eop = 0;
  int           last_eop_cyc = -100;
  int           sop_gap = 0;
  int           cw_bits = 0;
  int           cw_cnt = 0;
  logic [N-1:0] cw = '0;
  logic [N-1:0] last_cw = '0;

  task automatic chkw(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Parity by long division of msg*x^10 by g.
  function automatic logic [GDEG-1:0] calc_parity(input logic [K-1:0] msg);
    logic [N-1:0] v;
    v = {msg, {GDEG{1'b0}}};
    for (int i = N - 1; i >= int'(GDEG); i--) begin
      if (v[i]) v = v ^ (N'(G) << (i - int'(GDEG)));
    end
    return v[GDEG-1:0];
  endfunction

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] x;
    logic [3:0] r;
    x = {1'b0, a};
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x[3:0];
      x = x << 1;
      if (x[4]) x = x ^ 5'h13;
    end
    return r;
  endfunction

  function automatic logic [3:0] syn(input logic [N-1:0] c, input int j);
    logic [3:0] aj;
    logic [3:0] s;
    aj = 4'h1;
    for (int i = 0; i < j; i++) aj = gmul(aj, 4'h2);
    s = '0;
    for (int i = N - 1; i >= 0; i--) s = gmul(s, aj) ^ {3'b000, c[i]};
    return s;
  endfunction

  // One input cycle of the reference encoder; pushes expected output bits.
  task automatic model_step(input logic c, input logic sop, input logic val, input logic dat,
                            output logic rdy);
    logic [GDEG-1:0] par;
    rdy = (m_par_left == 0);
    if (!c) return;
    if (m_par_left > 0) begin
      m_par_left--;
    end else if (val) begin
      if (sop) begin
        m_msg = K'(dat);
        m_cnt = 1;
        exp_q.push_back('{1'b1, dat, 1'b0});
      end else if (m_cnt != 0) begin
        m_msg = {m_msg[K-2:0], dat};
        m_cnt++;
        exp_q.push_back('{1'b0, dat, 1'b0});
      end
      if (m_cnt == int'(K)) begin
        par = calc_parity(m_msg);
        for (int i = int'(GDEG) - 1; i >= 0; i--) exp_q.push_back('{1'b0, par[i], (i == 0)});
        m_par_left = GDEG;
        m_cnt = 0;
      end
    end
  endtask

  task automatic drive(input logic c, input logic sop, input logic val, input logic dat,
                       output logic acc);
    logic rdy;
    @(negedge clk);
    ce       = c;
    bus.isop = sop;
    bus.ival = val;
    bus.idat = dat;
    model_step(c, sop, val, dat, rdy);
    chk1("ordy", bus.ordy, rdy);
    acc = c & val & rdy;
  endtask

  task automatic idle(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'($urandom), 1'b0, 1'($urandom), acc);
  endtask

  task automatic send_bit(input logic sop, input logic dat, input int max_gap);
    logic acc;
    acc = 1'b0;
    if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    for (int t = 0; t < 40; t++) begin
      drive(1'b1, sop, 1'b1, dat, acc);
      if (acc) break;
    end
    if (!acc) chk1("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [K-1:0] msg, input int max_gap);
    for (int i = int'(K) - 1; i >= 0; i--) send_bit((i == int'(K) - 1), msg[i], max_gap);
  endtask

  task automatic wait_cw(input int target);
    for (int i = 0; i < 80 && cw_cnt < target; i++) idle(1);
    chk1("codeword_seen", (cw_cnt >= target), 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) idle(1);
    chkw("queue_drained", 32'(exp_q.size()), 0);
  endtask

  // Output monitor: sample mid-cycle after each enabled clock edge.
  always begin
    @(posedge clk);
    ce_s = ce;
    cyc++;
    @(negedge clk);
    if (mon_en && ce_s && rst_n) begin
      if (bus.oval) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_oval", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk1("osop", bus.osop, e.sop);
          chk1("odat", bus.odat, e.dat);
          chk1("oeop", bus.oeop, e.eop);
        end
        run++;
        if (bus.osop) begin
          cw      = {{(N-1){1'b0}}, bus.odat};
          cw_bits = 1;
          sop_gap = cyc - last_eop_cyc;
        end else begin
          cw      = {cw[N-2:0], bus.odat};
          cw_bits++;
        end
        if (bus.oeop) begin
          chkw("codeword_len", 32'(cw_bits), N);
          for (int j = 1; j <= 6; j++) chkw("syndrome", 32'(syn(cw, j)), 0);
          last_cw      = cw;
          cw_cnt++;
          last_eop_cyc = cyc;
          run_at_eop   = run;
        end
      end else begin
        chk1("idle_osop", bus.osop, 1'b0);
        chk1("idle_oeop", bus.oeop, 1'b0);
        chk1("idle_odat", bus.odat, 1'b0);
        run = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    logic acc;
    int   base;

    tbl[0] = '{5'b00000, 10'h000};
    tbl[1] = '{5'b00001, 10'h137};
    tbl[2] = '{5'b00010, 10'h26E};
    tbl[3] = '{5'b00100, 10'h1EB};
    tbl[4] = '{5'b01000, 10'h3D6};
    tbl[5] = '{5'b10000, 10'h29B};
    tbl[6] = '{5'b11111, 10'h3FF};

    bus.isop = 1'b0;
    bus.ival = 1'b0;
    bus.idat = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_osop", bus.osop, 1'b0);
    chk1("rst_oval", bus.oval, 1'b0);
    chk1("rst_oeop", bus.oeop, 1'b0);
    chk1("rst_odat", bus.odat, 1'b0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1 chk1("ordy_after_reset", bus.ordy, 1'b1);

    // Bits before any isop are dropped
    drive(1'b1, 1'b0, 1'b1, 1'b1, acc);
    drive(1'b1, 1'b0, 1'b1, 1'b0, acc);
    wait_drain();

    // Constant codeword table
    foreach (tbl[i]) begin
      base = cw_cnt;
      send_frame(tbl[i].msg, 0);
      wait_cw(base + 1);
      chkw("tbl_codeword", 32'(last_cw), 32'({tbl[i].msg, tbl[i].par}));
      chkw("tbl_oval_run", 32'(run_at_eop), N);
    end
    wait_drain();

    // Back-to-back frames with ival held high
    base = cw_cnt;
    send_frame(5'b10011, 0);
    send_frame(5'b01101, 0);
    wait_cw(base + 2);
    chkw("b2b_sop_gap", 32'(sop_gap), 1);
    chkw("b2b_oval_run", 32'(run_at_eop), 2 * N);
    wait_drain();

    // isop after 3 bits abandons the first frame
    base = cw_cnt;
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b1, 0);
    send_bit(1'b0, 1'b0, 1);
    send_frame(5'b10101, 1);
    wait_cw(base + 1);
    chkw("abandon_codeword", 32'(last_cw), 32'({5'b10101, 10'h247}));
    chkw("abandon_frames", 32'(cw_cnt - base), 1);
    wait_drain();

    // iclkena low mid-frame freezes state and outputs
    base = cw_cnt;
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, acc);
      chk1("ce_no_accept", acc, 1'b0);
      @(posedge clk);
      #1;
      chk1("ce_hold_oval", bus.oval, 1'b1);
      chk1("ce_hold_odat", bus.odat, 1'b0);
      chk1("ce_hold_osop", bus.osop, 1'b0);
    end
    send_bit(1'b0, 1'b1, 0);
    send_bit(1'b0, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    wait_cw(base + 1);
    chkw("ce_codeword", 32'(last_cw), 32'({5'b10110, 10'h11E}));
    wait_drain();

    // Reset in the middle of the parity phase
    send_frame(5'b11001, 0);
    idle(4);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk1("midrst_oval", bus.oval, 1'b0);
    chk1("midrst_osop", bus.osop, 1'b0);
    chk1("midrst_oeop", bus.oeop, 1'b0);
    chk1("midrst_odat", bus.odat, 1'b0);
    chk1("midrst_ordy", bus.ordy, 1'b1);
    exp_q.delete();
    m_par_left = 0;
    m_cnt      = 0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1 chk1("midrst_ordy_release", bus.ordy, 1'b1);
    base = cw_cnt;
    send_frame(5'b00111, 2);
    wait_cw(base + 1);
    chkw("midrst_codeword", 32'(last_cw), 32'({5'b00111, 10'h2B2}));
    wait_drain();

    // Random messages with random input gaps
    base = cw_cnt;
    for (int f = 0; f < 1000; f++) send_frame(K'($urandom), 3);
    wait_cw(base + 1000);
    wait_drain();
    chkw("random_frames", 32'(cw_cnt - base), 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
